// File: rtl/lcd_text_buffer.sv
// 32-character LCD frame buffer with host write port, frame clear and a
// 16-bit binary-to-decimal (double dabble) renderer writing 5 right-justified digits.
module lcd_text_buffer #(
  parameter int         NUM_DIGITS = 5,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             num_start,
  input  logic [15:0]      num_value,
  input  logic [4:0]       num_addr,
  output logic             busy,
  output logic             done,
  output logic [0:31][7:0] ascii
);

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [35:0] dd;          // {bcd[19:0], binary[15:0]} double-dabble shift register
  logic [4:0]  base_addr;
  logic [3:0]  bit_cnt;
  logic [2:0]  dig_cnt;
  logic        nz_seen;

  logic [3:0]  digit;
  logic        leading_blank;
  logic [7:0]  conv_char;
  logic [4:0]  conv_idx;
  logic        conv_we;

  function automatic logic [19:0] dabble_adj(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int n = 0; n < 5; n++) begin
      if (b[4*n +: 4] >= 4'd5)
        r[4*n +: 4] = b[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (num_start) state_nxt = CONV;
      CONV:  if (bit_cnt == 4'd15) state_nxt = WRITE;
      WRITE: if (dig_cnt == 3'(NUM_DIGITS - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Digits leave the top nibble of the BCD field, most significant first
  assign digit         = dd[35:32];
  assign leading_blank = !nz_seen && (digit == 4'd0) && (dig_cnt != 3'(NUM_DIGITS - 1));
  assign conv_char     = leading_blank ? BLANK_CHAR : (8'h30 + {4'h0, digit});
  assign conv_idx      = base_addr + {2'b00, dig_cnt};
  assign conv_we       = (state == WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dd        <= '0;
      base_addr <= '0;
      bit_cnt   <= '0;
      dig_cnt   <= '0;
      nz_seen   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state == CONV) || (state == WRITE);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (num_start) begin
            dd        <= {20'h0, num_value};
            base_addr <= num_addr;
            bit_cnt   <= '0;
            dig_cnt   <= '0;
            nz_seen   <= 1'b0;
          end
        end
        CONV: begin
          dd      <= {dabble_adj(dd[35:16]), dd[15:0]} << 1;
          bit_cnt <= bit_cnt + 4'd1;
        end
        WRITE: begin
          dd      <= {dd[31:16], 4'h0, dd[15:0]};
          dig_cnt <= dig_cnt + 3'd1;
          if (digit != 4'd0) nz_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-entry priority: clear, then converter digit, then host byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ascii <= {32{BLANK_CHAR}};
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (clr)
          ascii[i] <= BLANK_CHAR;
        else if (conv_we && (conv_idx == 5'(i)))
          ascii[i] <= conv_char;
        else if (wr_en && (wr_addr == 5'(i)))
          ascii[i] <= wr_data;
      end
    end
  end

endmodule
